// File: rtl/movegen_piece_iter.sv
// rtl/movegen_piece_iter.sv - white/black piece lists from a serial board load, replayed as a framed valid/ready stream
// Optional feature macro: MOVEGEN_PIECE_ITER_OVERFLOW_EN (drop pushes into a full list and raise sticky o_overflow)
module movegen_piece_iter #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pos_valid,
  input  logic             in_pos_sop,
  input  logic             in_pos_eop,
  input  logic [3:0]       in_pos_data,
  input  logic             in_wtp,
  input  logic             start,
  output logic             o_busy,
  output logic             o_piece_valid,
  input  logic             o_piece_ready,
  output logic [8:0]       o_piece_data,
  output logic             o_piece_sop,
  output logic             o_piece_eop,
  output logic [CNT_W-1:0] o_count_white,
  output logic [CNT_W-1:0] o_count_black,
  output logic             o_overflow
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [5:0]       sq_q, sq_d;
  logic             frame_open_q, frame_open_d;
  logic [8:0]       white_q [DEPTH];
  logic [8:0]       white_d [DEPTH];
  logic [8:0]       black_q [DEPTH];
  logic [8:0]       black_d [DEPTH];
  logic [CNT_W-1:0] cnt_w_q, cnt_w_d, cnt_b_q, cnt_b_d;
  logic [8:0]       iter_q [DEPTH];
  logic [8:0]       iter_d [DEPTH];
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sop_q, sop_d;
  state_t           state_q, state_d;
  logic [5:0]       beat_idx;
  logic [8:0]       entry;
  logic [CNT_W-1:0] snap_cnt;
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Board load: square counter, frame tracking, list clear on sop and newest-first push
  always_comb begin
    sq_d         = sq_q;
    frame_open_d = frame_open_q;
    white_d      = white_q;
    black_d      = black_q;
    cnt_w_d      = cnt_w_q;
    cnt_b_d      = cnt_b_q;
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
    ovf_d        = ovf_q;
`endif
    beat_idx     = in_pos_sop ? 6'd0 : sq_q;
    entry        = {in_pos_data[2:0], beat_idx};
    if (in_pos_valid) begin
      sq_d = beat_idx + 6'd1;
      if (in_pos_eop) begin
        frame_open_d = 1'b0;
      end else if (in_pos_sop) begin
        frame_open_d = 1'b1;
      end
      if (in_pos_sop) begin
        for (int i = 0; i < DEPTH; i++) begin
          white_d[i] = '0;
          black_d[i] = '0;
        end
        cnt_w_d = '0;
        cnt_b_d = '0;
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
        ovf_d   = 1'b0;
`endif
      end
      if (in_pos_data[2:0] != 3'd0) begin
        if (in_pos_data[3]) begin
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
          if (cnt_w_d == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = DEPTH - 1; i > 0; i--) white_d[i] = white_d[i-1];
            white_d[0] = entry;
            cnt_w_d    = cnt_w_d + CNT_ONE;
          end
`else
          for (int i = DEPTH - 1; i > 0; i--) white_d[i] = white_d[i-1];
          white_d[0] = entry;
          if (cnt_w_d != CNT_FULL) cnt_w_d = cnt_w_d + CNT_ONE;
`endif
        end else begin
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
          if (cnt_b_d == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = DEPTH - 1; i > 0; i--) black_d[i] = black_d[i-1];
            black_d[0] = entry;
            cnt_b_d    = cnt_b_d + CNT_ONE;
          end
`else
          for (int i = DEPTH - 1; i > 0; i--) black_d[i] = black_d[i-1];
          black_d[0] = entry;
          if (cnt_b_d != CNT_FULL) cnt_b_d = cnt_b_d + CNT_ONE;
`endif
        end
      end
    end
  end

  // Iterator FSM: snapshot the side-to-move list on start, then shift out one entry per accepted beat
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    sop_d    = sop_q;
    snap_cnt = in_wtp ? cnt_w_q : cnt_b_q;
    case (state_q)
      S_IDLE: begin
        if (start && !frame_open_q) begin
          state_d = S_EMIT;
          sop_d   = 1'b1;
          iter_d  = in_wtp ? white_q : black_q;
          if (snap_cnt == '0) begin
            // An empty side still produces one framed beat carrying zero data
            for (int i = 0; i < DEPTH; i++) iter_d[i] = '0;
            rem_d = CNT_ONE;
          end else begin
            rem_d = snap_cnt;
          end
        end
      end
      S_EMIT: begin
        if (o_piece_ready) begin
          sop_d = 1'b0;
          for (int i = 0; i < DEPTH - 1; i++) iter_d[i] = iter_q[i+1];
          iter_d[DEPTH-1] = '0;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_q         <= '0;
      frame_open_q <= 1'b0;
      cnt_w_q      <= '0;
      cnt_b_q      <= '0;
      rem_q        <= '0;
      sop_q        <= 1'b0;
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        white_q[i] <= '0;
        black_q[i] <= '0;
        iter_q[i]  <= '0;
      end
    end else begin
      sq_q         <= sq_d;
      frame_open_q <= frame_open_d;
      cnt_w_q      <= cnt_w_d;
      cnt_b_q      <= cnt_b_d;
      rem_q        <= rem_d;
      sop_q        <= sop_d;
      state_q      <= state_d;
      white_q      <= white_d;
      black_q      <= black_d;
      iter_q       <= iter_d;
    end
  end

`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
  // Sticky overflow flag, cleared by reset or a new board frame
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_busy        = (state_q == S_EMIT);
  assign o_piece_valid = (state_q == S_EMIT);
  assign o_piece_data  = (state_q == S_EMIT) ? iter_q[0] : 9'd0;
  assign o_piece_sop   = (state_q == S_EMIT) && sop_q;
  assign o_piece_eop   = (state_q == S_EMIT) && (rem_q == CNT_ONE);
  assign o_count_white = cnt_w_q;
  assign o_count_black = cnt_b_q;

endmodule

// File: tb/tb_movegen_piece_iter.sv
// tb/tb_movegen_piece_iter.sv - directed self-checking bench for movegen_piece_iter
module tb_movegen_piece_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_pos_valid, in_pos_sop, in_pos_eop;
  logic [3:0] in_pos_data;
  logic       in_wtp, start, o_piece_ready;

  logic       o_busy, o_piece_valid, o_piece_sop, o_piece_eop, o_overflow;
  logic [8:0] o_piece_data;
  logic [4:0] o_count_white, o_count_black;

  logic       busy2, valid2, sop2, eop2, ovf2;
  logic [8:0] data2;
  logic [1:0] cw2, cb2;

  logic [3:0] board [64];
  logic [2:0] back_rank [8];
  logic [8:0] exp_q [64];
  int         exp_n;
  int         checks = 0;
  int         errors = 0;
  logic       exp_ovf;
  logic [8:0] exp2_a, exp2_b;

  always #5 clk = ~clk;

  movegen_piece_iter #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_pos_valid(in_pos_valid), .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop),
    .in_pos_data(in_pos_data), .in_wtp(in_wtp), .start(start),
    .o_busy(o_busy), .o_piece_valid(o_piece_valid), .o_piece_ready(o_piece_ready),
    .o_piece_data(o_piece_data), .o_piece_sop(o_piece_sop), .o_piece_eop(o_piece_eop),
    .o_count_white(o_count_white), .o_count_black(o_count_black), .o_overflow(o_overflow)
  );

  movegen_piece_iter #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_pos_valid(in_pos_valid), .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop),
    .in_pos_data(in_pos_data), .in_wtp(in_wtp), .start(start),
    .o_busy(busy2), .o_piece_valid(valid2), .o_piece_ready(o_piece_ready),
    .o_piece_data(data2), .o_piece_sop(sop2), .o_piece_eop(eop2),
    .o_count_white(cw2), .o_count_black(cb2), .o_overflow(ovf2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
  endtask

  task automatic set_start_pos();
    back_rank = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    clear_board();
    for (int i = 0; i < 8; i++) begin
      board[i]      = {1'b1, back_rank[i]};
      board[8 + i]  = 4'b1001;
      board[48 + i] = 4'b0001;
      board[56 + i] = {1'b0, back_rank[i]};
    end
  endtask

  // Expected white stream: occupied white squares, highest index first
  task automatic fill_exp_white();
    exp_n = 0;
    for (int i = 63; i >= 0; i--) begin
      if (board[i][3] && board[i][2:0] != 3'd0) begin
        exp_q[exp_n] = {board[i][2:0], 6'(i)};
        exp_n++;
      end
    end
  endtask

  task automatic load_board(input int start_at);
    for (int i = 0; i < 64; i++) begin
      in_pos_valid = 1'b1;
      in_pos_sop   = (i == 0);
      in_pos_eop   = (i == 63);
      in_pos_data  = board[i];
      start        = (i == start_at);
      step();
    end
    in_pos_valid = 1'b0;
    in_pos_sop   = 1'b0;
    in_pos_eop   = 1'b0;
    in_pos_data  = 4'd0;
    start        = 1'b0;
  endtask

  task automatic do_start(input logic wtp);
    in_wtp = wtp;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic drain(input int first, input int n, input bit bp);
    int k;
    int c;
    logic [8:0] prev;
    bit stalled;
    k = first;
    c = 0;
    prev = 9'd0;
    stalled = 1'b0;
    while (k < n && c < 400) begin
      o_piece_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      chk("valid_hold", 32'(o_piece_valid), 32'd1);
      if (stalled) chk("stall_stable", 32'(o_piece_data), 32'(prev));
      if (o_piece_ready) begin
        chk("beat_data", 32'(o_piece_data), 32'(exp_q[k]));
        chk("beat_sop", 32'(o_piece_sop), 32'(k == 0));
        chk("beat_eop", 32'(o_piece_eop), 32'(k == n - 1));
        k++;
      end
      prev = o_piece_data;
      stalled = !o_piece_ready;
      step();
      c++;
    end
    o_piece_ready = 1'b1;
    chk("drain_done", 32'(k), 32'(n));
    chk("end_valid", 32'(o_piece_valid), 32'd0);
    chk("end_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_pos_valid = 1'b0; in_pos_sop = 1'b0; in_pos_eop = 1'b0; in_pos_data = 4'd0;
    in_wtp = 1'b0; start = 1'b0; o_piece_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(o_piece_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_piece_data), 32'd0);
    chk("rst_cnt_w", 32'(o_count_white), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    rst = 1'b0;
    step();

    // Start position; a start in the middle of the open frame must be ignored
    set_start_pos();
    fill_exp_white();
    load_board(10);
    chk("start_in_frame_ignored", 32'(o_busy), 32'd0);
    chk("cnt_white_16", 32'(o_count_white), 32'd16);
    chk("cnt_black_16", 32'(o_count_black), 32'd16);
    chk("ovf_clear_d16", 32'(o_overflow), 32'd0);
    do_start(1'b1);
    chk("start_latency_busy", 32'(o_busy), 32'd1);
    chk("first_beat_sq15", 32'(o_piece_data), 32'(9'b001_001_111));
    drain(0, exp_n, 1'b0);
    chk("last_beat_sq0", 32'(exp_q[15]), 32'(9'b100_000_000));

    // Backpressure: same stream with ready 1,0,0,1,...
    do_start(1'b1);
    drain(0, exp_n, 1'b1);

    // Empty black side, then single white king
    clear_board();
    board[4] = 4'b1110;
    load_board(-1);
    chk("cnt_white_1", 32'(o_count_white), 32'd1);
    chk("cnt_black_0", 32'(o_count_black), 32'd0);
    exp_q[0] = 9'd0;
    do_start(1'b0);
    drain(0, 1, 1'b0);
    exp_q[0] = 9'b110_000_100;
    do_start(1'b1);
    drain(0, 1, 1'b0);

    // Overflow on the DEPTH=2 instance with three white pawns at squares 8,9,10
    clear_board();
    board[8] = 4'b1001; board[9] = 4'b1001; board[10] = 4'b1001;
    load_board(-1);
`ifdef MOVEGEN_PIECE_ITER_OVERFLOW_EN
    exp_ovf = 1'b1; exp2_a = 9'b001_001_001; exp2_b = 9'b001_001_000;
`else
    exp_ovf = 1'b0; exp2_a = 9'b001_001_010; exp2_b = 9'b001_001_001;
`endif
    chk("d2_cnt_white", 32'(cw2), 32'd2);
    chk("d2_cnt_black", 32'(cb2), 32'd0);
    chk("d2_overflow", 32'(ovf2), 32'(exp_ovf));
    chk("d16_cnt_white_3", 32'(o_count_white), 32'd3);
    do_start(1'b1);
    chk("d2_busy", 32'(busy2), 32'd1);
    chk("d2_beat0", 32'(data2), 32'(exp2_a));
    chk("d2_beat0_sop", 32'(sop2), 32'd1);
    chk("d2_beat0_eop", 32'(eop2), 32'd0);
    chk("d16_beat0", 32'(o_piece_data), 32'(9'b001_001_010));
    step();
    chk("d2_beat1", 32'(data2), 32'(exp2_b));
    chk("d2_beat1_eop", 32'(eop2), 32'd1);
    step();
    chk("d2_done", 32'(valid2), 32'd0);
    chk("d16_beat2", 32'(o_piece_data), 32'(9'b001_001_000));
    chk("d16_beat2_eop", 32'(o_piece_eop), 32'd1);
    step();
    chk("d16_done", 32'(o_piece_valid), 32'd0);

    // Reload during EMIT: stream keeps the old snapshot
    set_start_pos();
    fill_exp_white();
    load_board(-1);
    do_start(1'b1);
    o_piece_ready = 1'b1;
    chk("reload_b0", 32'(o_piece_data), 32'(exp_q[0]));
    step();
    chk("reload_b1", 32'(o_piece_data), 32'(exp_q[1]));
    step();
    o_piece_ready = 1'b0;
    clear_board();
    board[20] = 4'b1101;
    load_board(-1);
    chk("reload_still_busy", 32'(o_busy), 32'd1);
    chk("reload_cnt_new", 32'(o_count_white), 32'd1);
    drain(2, 16, 1'b0);
    exp_q[0] = 9'b101_010_100;
    do_start(1'b1);
    drain(0, 1, 1'b0);

    // Reset in the middle of an emission
    set_start_pos();
    load_board(-1);
    do_start(1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(o_piece_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_sop", 32'(o_piece_sop), 32'd0);
    chk("mid_rst_eop", 32'(o_piece_eop), 32'd0);
    chk("mid_rst_data", 32'(o_piece_data), 32'd0);
    chk("mid_rst_cnt_w", 32'(o_count_white), 32'd0);
    chk("mid_rst_cnt_b", 32'(o_count_black), 32'd0);
    chk("mid_rst_ovf", 32'(o_overflow), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/movegen_piece_iter.md
# movegen_piece_iter

Parametrised piece-list iterator for the move generator. Captures the serial board load into separate white and black piece lists of configurable depth. On `start`, snapshots the side-to-move list into an iterator and emits one `{piece, rank, file}` entry per beat on a framed valid/ready stream. It succeeds the fixed 16-entry, always-shifting move stack: depth is now a parameter, the output honours backpressure, and the block adds counts, empty-side framing and overflow handling.

## Interface
- `DEPTH`, 16: entries per colour list and in the iterator; must be ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of the count outputs.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_pos_valid` input 1: serial board beat, one square per beat.
- `in_pos_sop` input 1: first square of a board frame (square index 0).
- `in_pos_eop` input 1: last square of a board frame.
- `in_pos_data` input 4: `{white, piece[2:0]}`; `piece == 0` means empty square.
- `in_wtp` input 1: side to move, sampled on `start`; 1 selects the white list.
- `start` input 1: single-cycle request to begin iteration.
- `o_busy` output 1: iterator is emitting.
- `o_piece_valid` output 1: output beat is valid.
- `o_piece_ready` input 1: consumer accepts the beat.
- `o_piece_data` output 9: `{piece[2:0], rank[2:0], file[2:0]}`.
- `o_piece_sop` output 1: first beat of an iteration.
- `o_piece_eop` output 1: last beat of an iteration.
- `o_count_white` output CNT_W: entries currently held in the white list.
- `o_count_black` output CNT_W: entries currently held in the black list.
- `o_overflow` output 1: sticky flag, a push was attempted while the list was full.

## Operation
- **Square counter (6 bits):**
  - Forced to 0 on a beat with `in_pos_sop`, otherwise increments on each `in_pos_valid` beat.
  - `rank = idx[5:3]`, `file = idx[2:0]`.
  - Wraps 63→0 when no sop is present.
- **Frame tracking:**
  - `frame_open` is set on a beat with `in_pos_sop` and no `in_pos_eop`.
  - It is cleared on any beat with `in_pos_eop`.
- **Clearing the lists:** a beat with `in_pos_sop` empties both lists. The sop square itself is then pushed in the same cycle if it is occupied.
- **Pushing:**
  - An occupied beat pushes `{piece, rank, file}` onto the list of its colour.
  - Entry 0 receives the new entry and existing entries shift toward `DEPTH-1`.
  - Counts increment on push and saturate at `DEPTH`.
- **Iterator FSM:**
  - **IDLE → EMIT:** on `start` when `!frame_open`. The selected list and its count are copied in parallel into the iterator, and `o_piece_sop` is set. `start` is ignored in EMIT or while `frame_open`.
  - **EMIT:**
    - The output shows iterator entry 0.
    - On `valid & ready`, the iterator shifts up by one and the remaining count decrements.
    - `o_piece_sop` clears after the first accept.
    - `o_piece_eop` = (remaining == 1).
  - **EMIT → IDLE:** on acceptance of the eop beat.
- **Emission order:** newest push first, i.e. descending square index within the frame.
- **Empty side:** if the copied count is 0, the block emits exactly one beat with data 0 and sop = eop = 1.
- **Load during EMIT:** board loads may proceed while emitting. They modify the colour lists only and leave the iterator snapshot unaffected.

## Timing
- **Reset:**
  - All outputs are 0, including `o_piece_data`.
  - Both lists and the iterator are emptied.
  - The square counter is 0, `frame_open` is 0, and the FSM is in IDLE.
  - Reset takes effect mid-load or mid-emit and takes priority over all other inputs in the same cycle.
- **Start latency:** `start` in cycle N gives `o_piece_valid`, `o_piece_sop` and `o_busy` high in cycle N+1.
- **Throughput:** one beat per cycle while `o_piece_ready` is held high.
- **Valid/ready rules:**
  - Once `valid` is raised, it stays high and `data`, `sop` and `eop` stay stable until accepted.
  - `ready` may be low for any number of cycles.
- **End of iteration:** eop accepted in cycle M gives `o_piece_valid` and `o_busy` low in cycle M+1. A `start` in cycle M+1 is accepted.
- **Counts:** `o_count_*` update one cycle after the pushing beat.
- **Simultaneous sop and start:** `start` is accepted when it coincides with a sop-only beat, because `frame_open` is still 0. The snapshot then takes the pre-clear list contents.

## Configuration
- **`MOVEGEN_PIECE_ITER_OVERFLOW_EN` defined:**
  - A push into a full list is dropped and the list is unchanged.
  - `o_overflow` is set and held until `rst` or the next `in_pos_sop` beat.
- **Not defined:**
  - A push into a full list shifts as normal, discarding entry `DEPTH-1`; the count stays at `DEPTH`.
  - `o_overflow` is tied to 0.

## Test plan
- **Start position, white to move:** reset, load the 64-square start position, `start` with `in_wtp = 1`, ready held high → 16 consecutive beats. First beat has sop and is the highest-index white square; last beat has eop and is square 0 data; `o_count_white == 16`.
- **Backpressure:** same run with ready toggling 1,0,0,1,… → identical data sequence, no beat lost or duplicated, data stable while stalled.
- **Empty side:** load a board with one white king at index 4 and no black pieces, `start` with `in_wtp = 0` → single beat with data 0, sop = eop = 1, then `o_busy` low.
- **Overflow, macro defined:** `DEPTH = 2`, load three white pawns → `o_count_white == 2`, `o_overflow == 1`, and iteration emits the first two squares. Without the macro: iteration emits the last two squares and `o_overflow == 0`.
- **Reload during EMIT and reset:**
  - Reload a new board mid-EMIT → the emitted stream matches the old snapshot, and the next `start` reflects the new board.
  - Assert `rst` mid-EMIT → all outputs 0 next cycle.
